// File: rtl/phase_sampler_windowed_pkg.sv
// Shared definitions for the windowed phase sampler: read-bank addressing
// and FSM state encodings.
package phase_sampler_windowed_pkg;

    localparam logic [31:0] PHASE_ADDR_BASE = 32'h0000_0400;
    localparam int          READ_STRIDE     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SNAP = 2'd2
    } state_t;

endpackage

// File: rtl/phase_counter_sat.sv
// One spin channel: synchronizes the asynchronous mismatch bit and
// accumulates it in a saturating up/down counter.
module phase_counter_sat
    import phase_sampler_windowed_pkg::*;
#(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          mismatch,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    input  logic [CW-1:0] cmax,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   m_sync;

    // A value already above the ceiling (ceiling lowered mid-run) is frozen
    // rather than pulled down, so the counter never jumps.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c,
                                               input logic          dn,
                                               input logic [CW-1:0] ceil);
        if (c > ceil) return c;
        if (dn)       return (c == '0)   ? c : c - ONE;
        return (c == ceil) ? c : c + ONE;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], mismatch};
    end

    assign m_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= sat_step(cnt, m_sync, cmax);
    end

endmodule

// File: rtl/phase_sampler_windowed.sv
// Windowed phase sampler: runs N saturating mismatch counters for a
// programmable window, snapshots them and serves the snapshot over a read port.
module phase_sampler_windowed
    import phase_sampler_windowed_pkg::*;
#(
    parameter int          N           = 3,
    parameter int          CW          = 16,
    parameter int          SYNC_STAGES = 3,
    parameter logic [31:0] BASE_ADDR   = PHASE_ADDR_BASE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   window_len,
    input  logic [CW-1:0] counter_max,
    input  logic [CW-1:0] counter_cutoff,
    input  logic [N-1:0]  outputs,
    input  logic [N-1:0]  external_spin,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  spin_est,
    input  logic          rd_en,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rd_data,
    output logic          rd_valid
);

    state_t        state, state_nxt;
    logic [31:0]   win_cnt;
    logic [CW-1:0] eff_cut;
    logic [CW-1:0] cnt  [N];
    logic [CW-1:0] snap [N];
    logic [N-1:0]  mismatch;
    logic          load, cnt_en, snap_en;
    logic [31:0]   rd_idx;
    logic [31:0]   rd_word;

    function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign eff_cut  = min_cw(counter_cutoff, counter_max);
    assign mismatch = outputs ^ external_spin;

    for (genvar g = 0; g < N; g++) begin : g_ch
        phase_counter_sat #(
            .CW          (CW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .clk      (clk),
            .rstn     (rstn),
            .mismatch (mismatch[g]),
            .load     (load),
            .en       (cnt_en),
            .load_val (eff_cut),
            .cmax     (counter_max),
            .cnt      (cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Restart outranks both stop and window expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (start)                        state_nxt = ST_RUN;
                else if (stop || win_cnt == 32'd1) state_nxt = ST_SNAP;
            end
            ST_SNAP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_RUN) || (state == ST_SNAP);
        load    = start && (state != ST_SNAP);
        cnt_en  = (state == ST_RUN) && !start;
        snap_en = (state == ST_SNAP);
    end

    // A zero window loads zero here and therefore never reaches the expiry value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                 win_cnt <= '0;
        else if (load)                             win_cnt <= window_len;
        else if (state == ST_RUN && win_cnt != '0) win_cnt <= win_cnt - 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done     <= 1'b0;
            spin_est <= '0;
            for (int i = 0; i < N; i++) snap[i] <= '0;
        end else begin
            done <= snap_en;
            if (snap_en) begin
                for (int i = 0; i < N; i++) begin
                    snap[i]     <= cnt[i];
                    spin_est[i] <= (cnt[i] >= eff_cut);
                end
            end
        end
    end

    // Addresses below the base wrap to a huge index and read as zero.
    assign rd_idx = (rd_addr - BASE_ADDR) >> $clog2(READ_STRIDE);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N; i++)
            if (rd_idx == 32'(i)) rd_word = 32'(snap[i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_phase_sampler_windowed.sv
// Scenario bench for phase_sampler_windowed: expected snapshot words are
// queued when a read is issued and compared when rd_valid returns.
module tb_phase_sampler_windowed;
    import phase_sampler_windowed_pkg::*;

    localparam int          N    = 3;
    localparam int          CW   = 8;
    localparam logic [31:0] BASE = PHASE_ADDR_BASE;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, stop;
    logic [31:0]   window_len;
    logic [CW-1:0] counter_max, counter_cutoff;
    logic [N-1:0]  outputs, external_spin;
    logic          busy, done;
    logic [N-1:0]  spin_est;
    logic          rd_en;
    logic [31:0]   rd_addr, rd_data;
    logic          rd_valid;

    logic          tog = 1'b0;
    logic          tog_en;
    logic [N-1:0]  out_base;

    int            vec  = 0;
    int            errs = 0;
    logic [31:0]   exp_q[$];

    assign outputs = out_base ^ {tog_en & tog, 2'b00};

    phase_sampler_windowed #(
        .N           (N),
        .CW          (CW),
        .SYNC_STAGES (3),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .stop           (stop),
        .window_len     (window_len),
        .counter_max    (counter_max),
        .counter_cutoff (counter_cutoff),
        .outputs        (outputs),
        .external_spin  (external_spin),
        .busy           (busy),
        .done           (done),
        .spin_est       (spin_est),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid)
    );

    always #5 clk = ~clk;
    always @(negedge clk) tog <= ~tog;

    task automatic setup(input logic [2:0] base, input logic te,
                         input logic [CW-1:0] cmax, input logic [CW-1:0] cut,
                         input logic [31:0] wl);
        out_base       = base;
        tog_en         = te;
        counter_max    = cmax;
        counter_cutoff = cut;
        window_len     = wl;
        repeat (5) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit got);
        bc  = 0;
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic count_done(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin
            if (done) n++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic v, output logic [31:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_en = 1'b0;
        v     = rd_valid;
        d     = rd_data;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({busy, done, spin_est, rd_valid} !== '0 || rd_data !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b spin=%b rv=%0b rd=%0d, want all 0",
                     busy, done, spin_est, rd_valid, rd_data);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_reset: got busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_accumulate();
        int          wl  [3] = '{20, 80, 40};
        int          cmx [3] = '{100, 100, 60};
        int          e0  [3] = '{30, 0, 10};
        int          e1  [3] = '{70, 100, 60};
        int          ex  [3];
        int          bc;
        bit          got;
        logic        v;
        logic [31:0] d, e;
        for (int r = 0; r < 3; r++) begin
            setup(3'b001, 1'b1, CW'(cmx[r]), 8'd50, 32'(wl[r]));
            start_pulse();
            wait_done(bc, got);
            vec++;
            if (!got) begin
                errs++;
                $display("FAIL acc_done row%0d: no done within bound, want done", r);
            end
            vec++;
            if (bc != wl[r] + 1) begin
                errs++;
                $display("FAIL acc_busy row%0d: got %0d busy cycles, want %0d", r, bc, wl[r] + 1);
            end
            vec++;
            if (spin_est !== 3'b110) begin
                errs++;
                $display("FAIL acc_spin row%0d: got %b, want 110", r, spin_est);
            end
            ex = '{e0[r], e1[r], 50};
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(32'(ex[i]));
                do_read(BASE + 32'(4 * i), v, d);
                e = exp_q.pop_front();
                vec++;
                if (v !== 1'b1 || d + 32'd1 < e || d > e + 32'd1 ||
                    (i < 2 && d !== e)) begin
                    errs++;
                    $display("FAIL acc_snap row%0d ch%0d: got valid=%0b data=%0d, want valid=1 data=%0d%s",
                             r, i, v, d, e, (i == 2) ? " +/-1" : "");
                end
            end
        end
    endtask

    task automatic test_cutoff_clamp();
        int          bc;
        bit          got;
        logic        v;
        logic [31:0] d, e;
        setup(3'b111, 1'b0, 8'd100, 8'd200, 32'd10);
        start_pulse();
        wait_done(bc, got);
        vec++;
        if (!got || spin_est !== 3'b000) begin
            errs++;
            $display("FAIL clamp_spin: got done=%0b spin=%b, want done=1 spin=000", got, spin_est);
        end
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(32'd90);
            do_read(BASE + 32'(4 * i), v, d);
            e = exp_q.pop_front();
            vec++;
            if (v !== 1'b1 || d !== e) begin
                errs++;
                $display("FAIL clamp_snap ch%0d: got valid=%0b data=%0d, want valid=1 data=%0d", i, v, d, e);
            end
        end
    endtask

    task automatic test_stop();
        int          n;
        logic        v;
        logic [31:0] d, e;
        setup(3'b010, 1'b0, 8'd100, 8'd50, 32'd0);
        start_pulse();
        repeat (14) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        count_done(10, n);
        vec++;
        if (n != 1 || spin_est !== 3'b101) begin
            errs++;
            $display("FAIL stop_unlimited: got %0d done pulses spin=%b, want 1 and 101", n, spin_est);
        end
        exp_q.push_back(32'd65);
        exp_q.push_back(32'd35);
        for (int i = 0; i < 2; i++) begin
            do_read(BASE + 32'(4 * i), v, d);
            e = exp_q.pop_front();
            vec++;
            if (v !== 1'b1 || d !== e) begin
                errs++;
                $display("FAIL stop_snap ch%0d: got valid=%0b data=%0d, want valid=1 data=%0d", i, v, d, e);
            end
        end

        setup(3'b000, 1'b0, 8'd100, 8'd50, 32'd5);
        start_pulse();
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        count_done(10, n);
        vec++;
        if (n != 1) begin
            errs++;
            $display("FAIL stop_expiry_collision: got %0d done pulses, want 1", n);
        end
        exp_q.push_back(32'd55);
        do_read(BASE, v, d);
        e = exp_q.pop_front();
        vec++;
        if (v !== 1'b1 || d !== e) begin
            errs++;
            $display("FAIL collision_snap: got valid=%0b data=%0d, want valid=1 data=%0d", v, d, e);
        end

        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        count_done(6, n);
        vec++;
        if (n != 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL stop_in_idle: got %0d done pulses busy=%0b, want 0 and 0", n, busy);
        end
    endtask

    task automatic test_restart();
        int          bc;
        bit          got;
        logic        v;
        logic [31:0] d, e;
        setup(3'b000, 1'b0, 8'd100, 8'd50, 32'd10);
        start_pulse();
        repeat (5) @(negedge clk);
        start_pulse();
        wait_done(bc, got);
        vec++;
        if (!got || bc != 11) begin
            errs++;
            $display("FAIL restart_window: got done=%0b busy_cycles=%0d, want done=1 busy_cycles=11", got, bc);
        end
        exp_q.push_back(32'd60);
        do_read(BASE + 32'd4, v, d);
        e = exp_q.pop_front();
        vec++;
        if (v !== 1'b1 || d !== e) begin
            errs++;
            $display("FAIL restart_snap: got valid=%0b data=%0d, want valid=1 data=%0d", v, d, e);
        end
    endtask

    task automatic test_reset_midrun();
        int          n;
        logic        v;
        logic [31:0] d, e;
        setup(3'b000, 1'b0, 8'd100, 8'd50, 32'd50);
        start_pulse();
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        vec++;
        if ({busy, done, spin_est, rd_valid} !== '0 || rd_data !== 32'd0) begin
            errs++;
            $display("FAIL reset_midrun: got busy=%0b done=%0b spin=%b rv=%0b rd=%0d, want all 0",
                     busy, done, spin_est, rd_valid, rd_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        count_done(20, n);
        vec++;
        if (n != 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_midrun_reset: got %0d done pulses busy=%0b, want 0 and 0", n, busy);
        end
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(32'd0);
            do_read(BASE + 32'(4 * i), v, d);
            e = exp_q.pop_front();
            vec++;
            if (v !== 1'b1 || d !== e) begin
                errs++;
                $display("FAIL reset_snap ch%0d: got valid=%0b data=%0d, want valid=1 data=%0d", i, v, d, e);
            end
        end
    endtask

    task automatic test_read_port();
        int          bc;
        bit          got;
        logic        v;
        logic [31:0] d, e;
        int          ex [4] = '{46, 54, 54, 0};
        setup(3'b001, 1'b0, 8'd100, 8'd50, 32'd4);
        start_pulse();
        wait_done(bc, got);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(ex[i]));
            do_read(BASE + 32'(4 * i), v, d);
            e = exp_q.pop_front();
            vec++;
            if (v !== 1'b1 || d !== e) begin
                errs++;
                $display("FAIL read_addr +%0d: got valid=%0b data=%0d, want valid=1 data=%0d", 4 * i, v, d, e);
            end
        end
        do_read(BASE + 32'd4, v, d);
        @(negedge clk);
        vec++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd54) begin
            errs++;
            $display("FAIL read_hold: got valid=%0b data=%0d, want valid=0 data=54", rd_valid, rd_data);
        end

        setup(3'b000, 1'b0, 8'd100, 8'd50, 32'd3);
        start_pulse();
        repeat (3) @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = BASE;
        exp_q.push_back(32'd46);
        @(negedge clk);
        rd_en = 1'b0;
        e = exp_q.pop_front();
        vec++;
        if (rd_valid !== 1'b1 || rd_data !== e || done !== 1'b1) begin
            errs++;
            $display("FAIL read_in_snap: got valid=%0b data=%0d done=%0b, want valid=1 data=%0d done=1",
                     rd_valid, rd_data, done, e);
        end
        exp_q.push_back(32'd53);
        do_read(BASE, v, d);
        e = exp_q.pop_front();
        vec++;
        if (v !== 1'b1 || d !== e) begin
            errs++;
            $display("FAIL read_after_snap: got valid=%0b data=%0d, want valid=1 data=%0d", v, d, e);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        window_len     = '0;
        counter_max    = '0;
        counter_cutoff = '0;
        external_spin  = '0;
        out_base       = '0;
        tog_en         = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;

        test_reset();
        test_accumulate();
        test_cutoff_clamp();
        test_stop();
        test_restart();
        test_reset_midrun();
        test_read_port();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
